bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_pick.sv | 35 +++
 rtl/bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_bus_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Types shared by the bus arbiter and its testbench.
//   state_e : arbiter FSM state encoding (IDLE, OWNED)
//   mode_e  : arbitration policy (MODE_FIXED = lowest index wins,
//             MODE_RR = round-robin starting after the last owner)
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational circular search for the first set request bit, starting at
// base_i and wrapping from N_SRC-1 back to 0.
//   req_i   : request vector (already masked by the caller)
//   base_i  : index where the search begins (must be < N_SRC)
//   found_o : at least one request bit is set
//   idx_o   : index of the winning request (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_SRC = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [SEL_W-1:0] base_i,
  output logic             found_o,
  output logic [SEL_W-1:0] idx_o
);

  always_comb begin
    int cand;
    cand    = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = int'(base_i) + i;
      if (cand >= N_SRC) cand = cand - N_SRC;
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// N_SRC-way bus arbiter with registered data mux, optional hold-time limit
// and a lock input that pins the current owner.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner; grant/sel/valid are 0
// OWNED | owner_q holds the bus; hold_q counts owned cycles
//
// Ports
//   clk    : sole clock, rising edge
//   rst    : synchronous active-high reset
//   req    : per-source request
//   in_bus : flattened source data, source i at [i*WIDTH +: WIDTH]
//   lock   : keep the current owner while high (ignored in IDLE)
//   out    : registered data of the owner, 0 when idle
//   valid  : a source owns the bus
//   grant  : one-hot owner, 0 when idle
//   sel    : binary owner index, 0 when idle
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    N_SRC    = 8,
  parameter mode_e MODE     = MODE_RR,
  parameter int    MAX_HOLD = 4,
  localparam int   SEL_W    = $clog2(N_SRC)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*WIDTH-1:0] in_bus,
  input  logic                   lock,
  output logic [WIDTH-1:0]       out,
  output logic                   valid,
  output logic [N_SRC-1:0]       grant,
  output logic [SEL_W-1:0]       sel
);

  // With MAX_HOLD == 0 the counter only needs to saturate; its value is unused.
  localparam int               HOLD_W     = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int               HOLD_SAT_I = (MAX_HOLD == 0) ? ((1 << HOLD_W) - 1) : (MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_SAT_I);
  localparam bit               HOLD_EN    = (MAX_HOLD != 0);
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(N_SRC - 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    owner_q, owner_d;
  logic [SEL_W-1:0]    last_q,  last_d;
  logic [HOLD_W-1:0]   hold_q,  hold_d;
  logic [WIDTH-1:0]    out_q,   out_d;

  logic [N_SRC-1:0]    owner_oh;
  logic [N_SRC-1:0]    pick_req;
  logic [SEL_W-1:0]    pick_base;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_found;
  logic                release_c;

  assign owner_oh = {{(N_SRC-1){1'b0}}, 1'b1} << owner_q;

  // While owned, the search only ever matters at release, where the departing
  // owner must not win again; masking it unconditionally keeps pick_found
  // meaning "someone else is waiting".
  assign pick_req  = (state_q == OWNED) ? (req & ~owner_oh) : req;

  // last_q equals owner_q while OWNED, so one base serves both IDLE and release.
  assign pick_base = (MODE == MODE_RR) ? ((last_q == LAST_IDX) ? '0 : last_q + 1'b1) : '0;

  rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_pick (
    .req_i   (pick_req),
    .base_i  (pick_base),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_IDX;
      hold_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
        end
      end
      OWNED: begin
        release_c = !lock &&
                    (!req[owner_q] || (HOLD_EN && (hold_q == HOLD_SAT) && pick_found));
        if (release_c) begin
          if (pick_found) begin
            owner_d = pick_idx;
            last_d  = pick_idx;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Data follows the owner that will be in place after this edge.
    out_d = (state_d == OWNED) ? in_bus[int'(owner_d)*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    valid = 1'b0;
    grant = '0;
    sel   = '0;
    if (state_q == OWNED) begin
      valid = 1'b1;
      grant = owner_oh;
      sel   = owner_q;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_pkg::*;

  logic        clk;
  logic [63:0] in_bus;

  logic        rst, lock;
  logic [7:0]  req;
  logic [7:0]  out_r, grant_r;
  logic        valid_r;
  logic [2:0]  sel_r;

  logic        rst_f, lock_f;
  logic [7:0]  req_f;
  logic [7:0]  out_f, grant_f;
  logic        valid_f;
  logic [2:0]  sel_f;

  int n_err = 0;
  int n_chk = 0;

  bus_arbiter #(.WIDTH(8), .N_SRC(8), .MODE(MODE_RR), .MAX_HOLD(4)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .in_bus(in_bus), .lock(lock),
    .out(out_r), .valid(valid_r), .grant(grant_r), .sel(sel_r)
  );

  bus_arbiter #(.WIDTH(8), .N_SRC(8), .MODE(MODE_FIXED), .MAX_HOLD(4)) dut_fx (
    .clk(clk), .rst(rst_f), .req(req_f), .in_bus(in_bus), .lock(lock_f),
    .out(out_f), .valid(valid_f), .grant(grant_f), .sel(sel_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       lock;
    logic [7:0] eg;
    logic [2:0] es;
    logic       ev;
    logic [7:0] eo;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_set(input string tag,
                           input logic [7:0] ag, input logic [7:0] eg,
                           input logic [2:0] as_, input logic [2:0] es,
                           input logic av, input logic ev,
                           input logic [7:0] ao, input logic [7:0] eo);
    chk({tag, ".grant"}, 32'(ag), 32'(eg));
    chk({tag, ".sel"},   32'(as_), 32'(es));
    chk({tag, ".valid"}, 32'(av), 32'(ev));
    chk({tag, ".out"},   32'(ao), 32'(eo));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) in_bus[i*8 +: 8] = 8'h10 + 8'(i);
    rst = 1'b1; req = '0; lock = 1'b0;
    rst_f = 1'b1; req_f = '0; lock_f = 1'b0;

    //             rst   req    lock  grant  sel   valid out
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'h12};
    vecs[3]  = '{1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'h12};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h09, 1'b0, 8'h08, 3'd3, 1'b1, 8'h13};
    vecs[6]  = '{1'b0, 8'h20, 1'b1, 8'h08, 3'd3, 1'b1, 8'h13};
    vecs[7]  = '{1'b0, 8'h20, 1'b1, 8'h08, 3'd3, 1'b1, 8'h13};
    vecs[8]  = '{1'b0, 8'h20, 1'b1, 8'h08, 3'd3, 1'b1, 8'h13};
    vecs[9]  = '{1'b0, 8'h20, 1'b1, 8'h08, 3'd3, 1'b1, 8'h13};
    vecs[10] = '{1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 8'h15};
    vecs[11] = '{1'b0, 8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'h15};
    vecs[12] = '{1'b1, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 8'h10};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 8'h01, 3'd0, 1'b1, 8'h10};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00};
    vecs[17] = '{1'b0, 8'h02, 1'b1, 8'h02, 3'd1, 1'b1, 8'h11};

    for (int v = 0; v < 18; v++) begin
      rst  = vecs[v].rst;
      req  = vecs[v].req;
      lock = vecs[v].lock;
      tick();
      check_set($sformatf("vec%0d", v), grant_r, vecs[v].eg, sel_r, vecs[v].es,
                valid_r, vecs[v].ev, out_r, vecs[v].eo);
    end

    // All sources requesting: each owns for 4 cycles, handing over with no gap.
    rst = 1'b1; req = '0; lock = 1'b0;
    tick();
    rst = 1'b0; req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      int own;
      tick();
      own = (k / 4) % 8;
      check_set($sformatf("rr_all.c%0d", k), grant_r, 8'(1 << own), sel_r, 3'(own),
                valid_r, 1'b1, out_r, 8'h10 + 8'(own));
    end
    req = '0;
    tick();
    check_set("rr_all.end", grant_r, 8'h00, sel_r, 3'd0, valid_r, 1'b0, out_r, 8'h00);

    // Fixed priority: owner 5 is not pre-empted by a lower-index newcomer.
    rst_f = 1'b0; req_f = 8'hA0;
    tick();
    check_set("fx.grant5", grant_f, 8'h20, sel_f, 3'd5, valid_f, 1'b1, out_f, 8'h15);
    req_f = 8'hA2;
    tick();
    check_set("fx.keep5a", grant_f, 8'h20, sel_f, 3'd5, valid_f, 1'b1, out_f, 8'h15);
    tick();
    check_set("fx.keep5b", grant_f, 8'h20, sel_f, 3'd5, valid_f, 1'b1, out_f, 8'h15);
    req_f = 8'h82;
    tick();
    check_set("fx.grant1", grant_f, 8'h02, sel_f, 3'd1, valid_f, 1'b1, out_f, 8'h11);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_set($sformatf("fx.hold1_%0d", j), grant_f, 8'h02, sel_f, 3'd1,
                valid_f, 1'b1, out_f, 8'h11);
    end
    tick();
    check_set("fx.forced7", grant_f, 8'h80, sel_f, 3'd7, valid_f, 1'b1, out_f, 8'h17);
    req_f = 8'h00;
    tick();
    check_set("fx.idle", grant_f, 8'h00, sel_f, 3'd0, valid_f, 1'b0, out_f, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
